// File: rtl/prt_pkg.sv
// prt_pkg: shared PRT definitions for the read arbiter slice.
//   Index_Size    - PRT slot index width
//   Table_Size    - number of PRT slots
//   FrameSize     - maximum frame length in bytes
//   DATA_SIZE     - PRT byte width
//   PRTReadOutput - one returned PRT byte (valid/data/last)
//   arb_state_e   - arbiter FSM states; ST_ABORT exists only with PRT_ARB_TIMEOUT_EN
package prt_pkg;

  localparam int Index_Size = 1;
  localparam int Table_Size = 2 ** Index_Size;
  localparam int FrameSize  = 1536;
  localparam int DATA_SIZE  = 8;

  typedef struct packed {
    logic                 valid;
    logic [DATA_SIZE-1:0] data;
    logic                 last;
  } PRTReadOutput;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_START  = 2'd1,
`ifdef PRT_ARB_TIMEOUT_EN
    ST_STREAM = 2'd2,
    ST_ABORT  = 2'd3
`else
    ST_STREAM = 2'd2
`endif
  } arb_state_e;

endpackage

// File: rtl/prt_rd_arbiter_rr_pick.sv
// prt_rr_pick: combinational round-robin selector.
//   req      in  NUM_REQ  request vector
//   rr_ptr   in  IDX_W    index with highest priority
//   pick     out NUM_REQ  one-hot winner (all zero when no request)
//   pick_idx out IDX_W    index of the winner (0 when no request)
module prt_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic [IDX_W-1:0]   pick_idx
);

  // Scan offsets from farthest to nearest so the requester closest to rr_ptr
  // is written last and therefore wins.
  always_comb begin
    int unsigned j;
    j        = 0;
    pick     = '0;
    pick_idx = '0;
    for (int unsigned k = NUM_REQ; k > 0; k--) begin
      j = ({{(32-IDX_W){1'b0}}, rr_ptr} + k - 1) % NUM_REQ;
      if (req[j]) begin
        pick     = '0;
        pick[j]  = 1'b1;
        pick_idx = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/prt_rd_arbiter.sv
// prt_rd_arbiter: round-robin arbiter granting one egress requester at a time
// exclusive read access to the PRT, streaming returned bytes back to it.
//   clk, reset                   clock, synchronous active-high reset
//   req / req_slot / rd_ready    per-requester request, wanted slot, byte acceptance
//   gnt                          one-hot grant, held for the whole transfer
//   prt_start_rd/prt_start_slot  one-cycle start-reading command to the PRT
//   prt_rd_en                    byte read request (owner's rd_ready while streaming)
//   prt_rd_valid/data/last       PRT byte return
//   out_valid/data/last          registered byte to the owner (1-cycle latency)
//   busy                         arbiter not idle
// Optional macro PRT_ARB_TIMEOUT_EN adds a stall watchdog with outputs
//   prt_inval, prt_inval_slot, timeout_err.
module prt_rd_arbiter
  import prt_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int SLOT_W      = Index_Size,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*SLOT_W-1:0] req_slot,
  input  logic [NUM_REQ-1:0]       rd_ready,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     prt_start_rd,
  output logic [SLOT_W-1:0]        prt_start_slot,
  output logic                     prt_rd_en,
  input  logic                     prt_rd_valid,
  input  logic [DATA_SIZE-1:0]     prt_rd_data,
  input  logic                     prt_rd_last,
  output logic                     out_valid,
  output logic [DATA_SIZE-1:0]     out_data,
  output logic                     out_last,
`ifdef PRT_ARB_TIMEOUT_EN
  output logic                     prt_inval,
  output logic [SLOT_W-1:0]        prt_inval_slot,
  output logic                     timeout_err,
`endif
  output logic                     busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e          state;
  logic [IDX_W-1:0]    rr_ptr;
  logic [IDX_W-1:0]    owner;
  logic                hold_idle;
  PRTReadOutput        out_q;
  logic [NUM_REQ-1:0]  pick;
  logic [IDX_W-1:0]    pick_idx;
  logic [SLOT_W-1:0]   pick_slot;
  logic [IDX_W-1:0]    next_ptr;

`ifdef PRT_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0]    stall_cnt;
  logic [SLOT_W-1:0]   slot_q;
`endif

  prt_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req      (req),
    .rr_ptr   (rr_ptr),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  always_comb begin
    pick_slot = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) pick_slot = req_slot[i*SLOT_W +: SLOT_W];
    end
  end

  assign next_ptr  = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);
  assign prt_rd_en = (state == ST_STREAM) && rd_ready[owner];
  assign busy      = (state != ST_IDLE);
  assign out_valid = out_q.valid;
  assign out_data  = out_q.data;
  assign out_last  = out_q.last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      rr_ptr         <= '0;
      owner          <= '0;
      hold_idle      <= 1'b0;
      gnt            <= '0;
      prt_start_rd   <= 1'b0;
      prt_start_slot <= '0;
      out_q          <= '0;
`ifdef PRT_ARB_TIMEOUT_EN
      stall_cnt      <= '0;
      slot_q         <= '0;
      prt_inval      <= 1'b0;
      prt_inval_slot <= '0;
      timeout_err    <= 1'b0;
`endif
    end else begin
      prt_start_rd   <= 1'b0;
      prt_start_slot <= '0;
      out_q.valid    <= prt_rd_valid;
      out_q.data     <= prt_rd_data;
      out_q.last     <= prt_rd_last;
`ifdef PRT_ARB_TIMEOUT_EN
      prt_inval      <= 1'b0;
      prt_inval_slot <= '0;
      timeout_err    <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          // The first idle cycle after a transfer never grants.
          if (hold_idle) begin
            hold_idle <= 1'b0;
          end else if (|req) begin
            owner          <= pick_idx;
            gnt            <= pick;
            prt_start_rd   <= 1'b1;
            prt_start_slot <= pick_slot;
`ifdef PRT_ARB_TIMEOUT_EN
            slot_q         <= pick_slot;
`endif
            state          <= ST_START;
          end
        end
        ST_START: state <= ST_STREAM;
        ST_STREAM: begin
          if (prt_rd_valid && prt_rd_last) begin
            state     <= ST_IDLE;
            gnt       <= '0;
            rr_ptr    <= next_ptr;
            hold_idle <= 1'b1;
`ifdef PRT_ARB_TIMEOUT_EN
            stall_cnt <= '0;
`endif
          end
`ifdef PRT_ARB_TIMEOUT_EN
          else if (prt_rd_valid) begin
            stall_cnt <= '0;
          end else if (prt_rd_en) begin
            // Abort on the edge that completes the TIMEOUT_CYC-th stall cycle.
            if (stall_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
              state          <= ST_ABORT;
              stall_cnt      <= '0;
              prt_inval      <= 1'b1;
              prt_inval_slot <= slot_q;
              timeout_err    <= 1'b1;
            end else begin
              stall_cnt <= stall_cnt + CNT_W'(1);
            end
          end
`endif
        end
`ifdef PRT_ARB_TIMEOUT_EN
        ST_ABORT: begin
          state     <= ST_IDLE;
          gnt       <= '0;
          rr_ptr    <= next_ptr;
          hold_idle <= 1'b1;
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
